// File: rtl/rpdiag_seq_if.sv
// Diagnostic-mode signal bundle between the maintenance register and the read sequencer.
// Inputs are register-sourced levels synchronous to clk; outputs are registered status bits.
interface rpdiag_seq_if;
   logic devRESET;
   logic rpDRVCLR;
   logic rpDMD;
   logic rpDCLK;
   logic rpDIND;
   logic rpDSCK;
   logic rpDRDD;
   logic rpFMT22;
   logic rpZD;
   logic rpSBD;
   logic rpDFE;
   logic rpECE;
   logic rpDWRD;
   logic rpSDONE;

   modport master (
      output devRESET, rpDRVCLR, rpDMD, rpDCLK, rpDIND, rpDSCK, rpDRDD, rpFMT22,
      input  rpZD, rpSBD, rpDFE, rpECE, rpDWRD, rpSDONE
   );

   modport slave (
      input  devRESET, rpDRVCLR, rpDMD, rpDCLK, rpDIND, rpDSCK, rpDRDD, rpFMT22,
      output rpZD, rpSBD, rpDFE, rpECE, rpDWRD, rpSDONE
   );
endinterface

// File: rtl/rpdiag_seq.sv
// Diagnostic read sequencer: walks preamble/sync/data/ECC one bit per rising DCLK level.
// Status outputs are registered, one clk after the DCLK/DSCK/DIND rise; no backpressure.
module rpdiag_seq #(
   parameter int         ZEROS    = 16,
   parameter logic [7:0] SYNCBYTE = 8'b1000_0001,
   parameter int         WORDS    = 256,
   parameter int         ECCBITS  = 32
) (
   input logic          clk,
   input logic          rst,
   rpdiag_seq_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, PRE, SYNC, DATA, ECC} state_t;

   localparam logic [7:0]  ZMIN     = 8'(ZEROS);
   localparam logic [12:0] LAST16   = 13'(WORDS * 16 - 1);
   localparam logic [12:0] LAST18   = 13'(WORDS * 18 - 1);
   localparam logic [12:0] ECC_LAST = 13'(ECCBITS - 1);

   state_t      state, state_n;
   logic [7:0]  zcnt, zcnt_n;
   logic [3:0]  scnt, scnt_n;
   logic [7:0]  shreg, shreg_n;
   logic [12:0] bcnt, bcnt_n;
   logic        fmt16, fmt16_n;
   logic        dclk_d, dind_d, dsck_d;
   logic        zd, sbd, dfe, ece, dwrd, sdone;
   logic        zd_n, sbd_n, dfe_n, ece_n, dwrd_n, sdone_n;
   logic        clk_edge, sec_edge, abort;
   logic [12:0] data_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         zcnt   <= '0;
         scnt   <= '0;
         shreg  <= '0;
         bcnt   <= '0;
         fmt16  <= 1'b0;
         dclk_d <= 1'b0;
         dind_d <= 1'b0;
         dsck_d <= 1'b0;
         zd     <= 1'b0;
         sbd    <= 1'b0;
         dfe    <= 1'b0;
         ece    <= 1'b0;
         dwrd   <= 1'b0;
         sdone  <= 1'b0;
      end else begin
         state  <= state_n;
         zcnt   <= zcnt_n;
         scnt   <= scnt_n;
         shreg  <= shreg_n;
         bcnt   <= bcnt_n;
         fmt16  <= fmt16_n;
         dclk_d <= bus.rpDCLK;
         dind_d <= bus.rpDIND;
         dsck_d <= bus.rpDSCK;
         zd     <= zd_n;
         sbd    <= sbd_n;
         dfe    <= dfe_n;
         ece    <= ece_n;
         dwrd   <= dwrd_n;
         sdone  <= sdone_n;
      end
   end

   always_comb begin
      state_n   = state;
      zcnt_n    = zcnt;
      scnt_n    = scnt;
      shreg_n   = shreg;
      bcnt_n    = bcnt;
      fmt16_n   = fmt16;
      dwrd_n    = dwrd;
      sdone_n   = 1'b0;
      clk_edge  = bus.rpDCLK & ~dclk_d;
      sec_edge  = (bus.rpDIND & ~dind_d) | (bus.rpDSCK & ~dsck_d);
      abort     = ~bus.rpDMD | bus.devRESET | bus.rpDRVCLR;
      data_last = fmt16 ? LAST16 : LAST18;

      if (abort) begin
         state_n = IDLE;
         zcnt_n  = '0;
         scnt_n  = '0;
         shreg_n = '0;
         bcnt_n  = '0;
         fmt16_n = 1'b0;
      end else if (sec_edge) begin
         // a sector/index mark restarts the walk; a coincident bit clock is dropped
         state_n = PRE;
         zcnt_n  = '0;
         bcnt_n  = '0;
      end else if (clk_edge) begin
         case (state)
            PRE: begin
               if (!bus.rpDRDD) begin
                  if (zcnt != 8'hFF) zcnt_n = zcnt + 8'd1;
               end else if (zcnt >= ZMIN) begin
                  shreg_n = 8'h01;
                  scnt_n  = 4'd1;
                  state_n = SYNC;
               end else begin
                  zcnt_n = '0;
               end
            end
            SYNC: begin
               shreg_n = {shreg[6:0], bus.rpDRDD};
               scnt_n  = scnt + 4'd1;
               if (scnt == 4'd7) begin
                  if (shreg_n == SYNCBYTE) begin
                     state_n = DATA;
                     bcnt_n  = '0;
                     fmt16_n = bus.rpFMT22;
                  end else begin
                     state_n = PRE;
                     zcnt_n  = '0;
                  end
               end
            end
            DATA: begin
               dwrd_n = bus.rpDRDD;
               bcnt_n = bcnt + 13'd1;
               if (bcnt == data_last) begin
                  state_n = ECC;
                  bcnt_n  = '0;
               end
            end
            ECC: begin
               dwrd_n = bus.rpDRDD;
               bcnt_n = bcnt + 13'd1;
               if (bcnt == ECC_LAST) begin
                  state_n = IDLE;
                  bcnt_n  = '0;
                  sdone_n = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // loopback bit only lives inside the data and ECC fields
      if (state_n != DATA && state_n != ECC) dwrd_n = 1'b0;
      zd_n  = (state_n == PRE || state_n == SYNC) && (zcnt_n >= ZMIN);
      sbd_n = (state_n == DATA) || (state_n == ECC);
      dfe_n = (state_n == DATA);
      ece_n = (state_n == ECC);
   end

   assign bus.rpZD    = zd;
   assign bus.rpSBD   = sbd;
   assign bus.rpDFE   = dfe;
   assign bus.rpECE   = ece;
   assign bus.rpDWRD  = dwrd;
   assign bus.rpSDONE = sdone;
endmodule

// File: tb/tb_rpdiag_seq.sv
// Directed bench for rpdiag_seq: sector-position model compared every clk plus literal checkpoints.
module tb_rpdiag_seq;
   logic clk;
   logic rst;
   int   nvec;
   int   errs;
   int   nsdone;
   bit   en;

   rpdiag_seq_if bus();

   rpdiag_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 hunting preamble, 2 collecting sync, 3 data, 4 ecc
   int   m_ph;
   int   m_zrun;
   int   m_left;
   bit   m_sq[$];
   logic m_wrd, m_done;
   logic p_clk, p_ind, p_sck;
   logic ce, se;
   logic [7:0] m_byte;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph = 0; m_zrun = 0; m_left = 0; m_wrd = 0; m_done = 0;
         p_clk = 0; p_ind = 0; p_sck = 0;
         m_sq.delete();
      end else begin
         ce = bus.rpDCLK && !p_clk;
         se = (bus.rpDIND && !p_ind) || (bus.rpDSCK && !p_sck);
         p_clk = bus.rpDCLK; p_ind = bus.rpDIND; p_sck = bus.rpDSCK;
         m_done = 0;
         if (!bus.rpDMD || bus.devRESET || bus.rpDRVCLR) begin
            m_ph = 0; m_zrun = 0; m_wrd = 0;
         end else if (se) begin
            m_ph = 1; m_zrun = 0; m_wrd = 0;
         end else if (ce) begin
            case (m_ph)
               1: begin
                  if (!bus.rpDRDD) m_zrun = (m_zrun >= 255) ? 255 : m_zrun + 1;
                  else if (m_zrun >= 16) begin
                     m_ph = 2; m_sq.delete(); m_sq.push_back(1'b1);
                  end else m_zrun = 0;
               end
               2: begin
                  m_sq.push_back(bus.rpDRDD);
                  if (m_sq.size() == 8) begin
                     for (int i = 0; i < 8; i++) m_byte[7-i] = m_sq[i];
                     if (m_byte == 8'h81) begin
                        m_ph = 3; m_wrd = 0;
                        m_left = bus.rpFMT22 ? 256 * 16 : 256 * 18;
                     end else begin
                        m_ph = 1; m_zrun = 0;
                     end
                  end
               end
               3: begin
                  m_wrd = bus.rpDRDD; m_left--;
                  if (m_left == 0) begin m_ph = 4; m_left = 32; end
               end
               4: begin
                  m_wrd = bus.rpDRDD; m_left--;
                  if (m_left == 0) begin m_ph = 0; m_wrd = 0; m_done = 1; end
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("zd",    16'(bus.rpZD),    16'(((m_ph == 1) || (m_ph == 2)) && (m_zrun >= 16)));
         chk("sbd",   16'(bus.rpSBD),   16'((m_ph == 3) || (m_ph == 4)));
         chk("dfe",   16'(bus.rpDFE),   16'(m_ph == 3));
         chk("ece",   16'(bus.rpECE),   16'(m_ph == 4));
         chk("dwrd",  16'(bus.rpDWRD),  16'(((m_ph == 3) || (m_ph == 4)) ? m_wrd : 1'b0));
         chk("sdone", 16'(bus.rpSDONE), 16'(m_done));
         if (bus.rpSDONE) nsdone++;
      end
   end

   task automatic step(input logic b);
      bus.rpDCLK = 1'b1; bus.rpDRDD = b;
      @(negedge clk);
      bus.rpDCLK = 1'b0;
      @(negedge clk);
   endtask

   task automatic zeros(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic sync(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) step(v[i]);
   endtask

   task automatic pulse_sck();
      bus.rpDSCK = 1'b1; @(negedge clk);
      bus.rpDSCK = 1'b0; @(negedge clk);
   endtask

   task automatic pulse_ind();
      bus.rpDIND = 1'b1; @(negedge clk);
      bus.rpDIND = 1'b0; @(negedge clk);
   endtask

   initial begin
      int n;
      int s0;
      logic [7:0] bad;
      nvec = 0; errs = 0; nsdone = 0; en = 0;
      bus.devRESET = 0; bus.rpDRVCLR = 0; bus.rpDMD = 0; bus.rpDCLK = 0;
      bus.rpDIND = 0; bus.rpDSCK = 0; bus.rpDRDD = 0; bus.rpFMT22 = 1;
      rst = 1'b1;
      #2 rst = 1'b0;
      en = 1;
      repeat (3) @(negedge clk);
      chk("rst_outs", 16'({bus.rpZD, bus.rpSBD, bus.rpDFE, bus.rpECE, bus.rpDWRD, bus.rpSDONE}), 16'd0);
      rst = 1'b1;
      @(negedge clk);
      bus.rpDMD = 1'b1;
      @(negedge clk);

      // 16-bit sector, with a DCLK held high for 50 clks as the 15th zero
      pulse_sck();
      zeros(14);
      bus.rpDCLK = 1'b1; bus.rpDRDD = 1'b0;
      repeat (50) @(negedge clk);
      bus.rpDCLK = 1'b0; @(negedge clk);
      chk("held_dclk_zd", 16'(bus.rpZD), 16'd0);
      step(1'b0);
      chk("zd_16th_zero", 16'(bus.rpZD), 16'd1);
      for (int i = 7; i >= 1; i--) step(i == 7);
      chk("sbd_before_8th", 16'(bus.rpSBD), 16'd0);
      step(1'b1);
      chk("sbd_after_sync", 16'({bus.rpSBD, bus.rpDFE}), 16'd3);
      n = 0;
      while (bus.rpDFE && n < 6000) begin step(1'($urandom_range(0, 1))); n++; end
      chk("dfe_len16", 16'(n), 16'd4096);
      chk("ece_after_data", 16'(bus.rpECE), 16'd1);
      s0 = nsdone; n = 0;
      while (bus.rpECE && n < 100) begin step(1'($urandom_range(0, 1))); n++; end
      chk("ece_len", 16'(n), 16'd32);
      chk("sdone_count", 16'(nsdone - s0), 16'd1);
      chk("idle_outs", 16'({bus.rpZD, bus.rpSBD, bus.rpDFE, bus.rpECE, bus.rpDWRD, bus.rpSDONE}), 16'd0);

      // 18-bit sector; format flip mid-field must not change the length
      bus.rpFMT22 = 1'b0;
      pulse_ind();
      zeros(16);
      sync(8'h81);
      chk("dfe18_start", 16'(bus.rpDFE), 16'd1);
      n = 0;
      while (bus.rpDFE && n < 6000) begin
         if (n == 100) bus.rpFMT22 = 1'b1;
         step(1'($urandom_range(0, 1))); n++;
      end
      chk("dfe_len18", 16'(n), 16'd4608);
      repeat (10) step(1'b1);
      bus.rpDCLK = 1'b1; bus.rpDSCK = 1'b1; bus.rpDRDD = 1'b0;
      @(negedge clk);
      bus.rpDCLK = 1'b0; bus.rpDSCK = 1'b0;
      @(negedge clk);
      chk("restart_outs", 16'({bus.rpZD, bus.rpSBD, bus.rpECE}), 16'd0);
      zeros(15);
      chk("restart_zcnt0", 16'(bus.rpZD), 16'd0);
      step(1'b0);
      chk("restart_zd16", 16'(bus.rpZD), 16'd1);

      // short preamble then abort by DMD
      pulse_sck();
      zeros(10);
      step(1'b1);
      chk("short_pre_zd", 16'(bus.rpZD), 16'd0);
      zeros(15);
      chk("second_run15", 16'(bus.rpZD), 16'd0);
      step(1'b0);
      chk("second_run16", 16'(bus.rpZD), 16'd1);
      sync(8'h81);
      chk("short_pre_sbd", 16'(bus.rpSBD), 16'd1);
      repeat (100) step(1'($urandom_range(0, 1)));
      bus.rpDMD = 1'b0;
      @(negedge clk);
      chk("abort_outs", 16'({bus.rpSBD, bus.rpDFE}), 16'd0);
      repeat (5) step(1'b1);
      bus.rpDMD = 1'b1;
      @(negedge clk);
      zeros(20);
      chk("no_progress", 16'(bus.rpZD), 16'd0);
      pulse_ind();
      zeros(16);
      chk("resume_zd", 16'(bus.rpZD), 16'd1);

      // saturating preamble counter, bad sync byte, then drive clear mid-data
      pulse_sck();
      zeros(261);
      chk("zcnt_sat", 16'(bus.rpZD), 16'd1);
      bad = 8'b1000_0011;
      for (int i = 7; i >= 1; i--) step(bad[i]);
      chk("zd_in_sync", 16'(bus.rpZD), 16'd1);
      step(bad[0]);
      chk("bad_sync", 16'({bus.rpZD, bus.rpSBD}), 16'd0);
      zeros(16);
      sync(8'h81);
      chk("good_after_bad", 16'({bus.rpSBD, bus.rpDFE}), 16'd3);
      repeat (20) step(1'b1);
      bus.rpDRVCLR = 1'b1;
      @(negedge clk);
      chk("drvclr_outs", 16'({bus.rpSBD, bus.rpDFE, bus.rpDWRD}), 16'd0);
      bus.rpDRVCLR = 1'b0;
      repeat (2) @(negedge clk);

      en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end
endmodule
